// File: rtl/fdiv_seq_if.sv
// Operand request / quotient response bundle for fdiv_seq.
// The unit uses the slave modport; the requester/consumer uses master.
interface fdiv_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        ovf;

   modport master (output in_valid, x1, x2, out_ready,
                   input  in_ready, out_valid, y, ovf);
   modport slave  (input  in_valid, x1, x2, out_ready,
                   output in_ready, out_valid, y, ovf);
endinterface

// File: rtl/fdiv_seq.sv
// Iterative binary32 divider y = x1 / x2: 26-step restoring mantissa division, RNE, FTZ.
// Optional IEEE flags output {nv, dz, uf} enabled by defining FDIV_FLAGS_EN.
module fdiv_seq (
   input  logic       clk,
   input  logic       rstn,
   fdiv_seq_if.slave  bus
`ifdef FDIV_FLAGS_EN
   ,
   output logic [2:0] flags
`endif
);
   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_e;

   localparam logic [4:0]  LAST_ITER = 5'd25;
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;

   state_e      state_q, state_d;
   logic [24:0] r_q, r_d;
   logic [23:0] m2_q, m2_d;
   logic [25:0] q_q, q_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [7:0]  e1_q, e1_d, e2_q, e2_d;
   logic        sign_q, sign_d;
   logic [31:0] y_q, y_d;
   logic        ovf_q, ovf_d;
`ifdef FDIV_FLAGS_EN
   logic [2:0]  flags_q, flags_d;
`endif

   // Operand decode straight off the bus; only used on the accept edge.
   logic        s1, s2, sgn;
   logic [7:0]  e1, e2;
   logic [22:0] f1, f2;
   logic        nan1, nan2, inf1, inf2, zero1, zero2;

   assign {s1, e1, f1} = bus.x1;
   assign {s2, e2, f2} = bus.x2;
   assign sgn   = s1 ^ s2;
   assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
   assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
   assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
   assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
   assign zero1 = (e1 == 8'd0);
   assign zero2 = (e2 == 8'd0);

   logic        is_special, spec_nv, spec_dz;
   logic [31:0] spec_y;

   // NOTE: every signal driven in an always_comb gets a default first, so no
   // path through the if/case leaves it unassigned and a latch is inferred.
   always_comb begin
      is_special = 1'b1;
      spec_nv    = 1'b0;
      spec_dz    = 1'b0;
      spec_y     = {sgn, 31'd0};
      if (nan1 || nan2) begin
         spec_y = QNAN;
      end else if ((inf1 && inf2) || (zero1 && zero2)) begin
         spec_y  = QNAN;
         spec_nv = 1'b1;
      end else if (inf1) begin
         spec_y = {sgn, 8'hFF, 23'd0};
      end else if (inf2) begin
         spec_y = {sgn, 31'd0};
      end else if (zero2) begin
         spec_y  = {sgn, 8'hFF, 23'd0};
         spec_dz = 1'b1;
      end else if (zero1) begin
         spec_y = {sgn, 31'd0};
      end else begin
         is_special = 1'b0;
      end
   end

   // Remainder stays below 2*m2, so a 24-bit subtract is exact whenever r >= m2.
   logic        r_ge;
   logic [23:0] r_sub;

   assign r_ge  = r_q >= {1'b0, m2_q};
   assign r_sub = r_q[23:0] - m2_q;

   logic [22:0]       frac;
   logic              guard, sticky, rnd;
   logic signed [9:0] exp_pre, exp_n;
   logic [32:0]       ef;
   logic [31:0]       norm_y;
   logic              norm_ovf, norm_uf;

   always_comb begin
      if (q_q[25]) begin
         frac    = q_q[24:2];
         guard   = q_q[1];
         sticky  = q_q[0] | (|r_q);
         exp_pre = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127;
      end else begin
         frac    = q_q[23:1];
         guard   = q_q[0];
         sticky  = |r_q;
         exp_pre = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd126;
      end
      rnd = guard & (sticky | frac[0]);
      // Rounding {exp, frac} as one word lets a fraction carry bump the exponent.
      ef    = {exp_pre, frac} + {32'd0, rnd};
      exp_n = $signed(ef[32:23]);

      norm_ovf = 1'b0;
      norm_uf  = 1'b0;
      norm_y   = {sign_q, exp_n[7:0], ef[22:0]};
      if (exp_n >= 10'sd255) begin
         norm_y   = {sign_q, 8'hFF, 23'd0};
         norm_ovf = 1'b1;
      end else if (exp_n <= 10'sd0) begin
         norm_y  = {sign_q, 31'd0};
         norm_uf = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      m2_d    = m2_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      e1_d    = e1_q;
      e2_d    = e2_q;
      sign_d  = sign_q;
      y_d     = y_q;
      ovf_d   = ovf_q;
`ifdef FDIV_FLAGS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               e1_d   = e1;
               e2_d   = e2;
               sign_d = sgn;
               m2_d   = {1'b1, f2};
               r_d    = {2'b01, f1};
               q_d    = 26'd0;
               cnt_d  = 5'd0;
               if (is_special) begin
                  y_d     = spec_y;
                  ovf_d   = 1'b0;
`ifdef FDIV_FLAGS_EN
                  flags_d = {spec_nv, spec_dz, 1'b0};
`endif
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            q_d   = {q_q[24:0], r_ge};
            r_d   = r_ge ? {r_sub, 1'b0} : {r_q[23:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) state_d = NORM;
         end
         NORM: begin
            y_d     = norm_y;
            ovf_d   = norm_ovf;
`ifdef FDIV_FLAGS_EN
            flags_d = {2'b00, norm_uf};
`endif
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         r_q     <= '0;
         m2_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         e1_q    <= '0;
         e2_q    <= '0;
         sign_q  <= 1'b0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
`ifdef FDIV_FLAGS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         m2_q    <= m2_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         e1_q    <= e1_d;
         e2_q    <= e2_d;
         sign_q  <= sign_d;
         y_q     <= y_d;
         ovf_q   <= ovf_d;
`ifdef FDIV_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;
`ifdef FDIV_FLAGS_EN
   assign flags         = flags_q;
`endif
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: vector table plus stall, ignored-request and mid-op reset sequences.
// Latency is counted as clock edges after the accept edge (special cases 0, normal path 27).
module tb_fdiv_seq;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fdiv_seq_if bus();
   logic [2:0] flags;

`ifdef FDIV_FLAGS_EN
   fdiv_seq dut (.clk(clk), .rstn(rstn), .bus(bus), .flags(flags));
`else
   fdiv_seq dut (.clk(clk), .rstn(rstn), .bus(bus));
   assign flags = 3'b000;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        ovf;
      logic [2:0]  fl;   // {nv, dz, uf}
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called at a negedge with the unit idle; returns at the negedge where out_valid is seen.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output logic ovf, output logic [2:0] fl,
                         output int lat, output logic seen);
      bus.in_valid = 1'b1;
      bus.x1 = a;
      bus.x2 = b;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      y   = bus.y;
      ovf = bus.ovf;
      fl  = flags;
   endtask

   logic [31:0] y_r;
   logic        ovf_r, seen_r;
   logic [2:0]  fl_r;
   int          lat_r;

   initial begin
      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 3'b000, 27}; // 6/2
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 3'b000, 27}; // 1/3 round up
      vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 27}; // 1/1
      vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b0, 3'b010, 0};  // -1/0
      vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 3'b100, 0};  // 0/0
      vecs[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, 3'b000, 27}; // overflow
      vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 3'b001, 27}; // flush to zero
      vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 3'b000, 0};  // NaN in
      vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 3'b100, 0};  // inf/inf
      vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 3'b000, 0};  // -inf/2
      vecs[10] = '{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0, 3'b000, 0};  // 2/-inf
      vecs[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 3'b000, 0};  // -0/2
      vecs[12] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 3'b000, 0};  // denormal dividend
      vecs[13] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 1'b0, 3'b010, 0};  // denormal divisor
      vecs[14] = '{32'hC0A00000, 32'h40000000, 32'hC0200000, 1'b0, 3'b000, 27}; // -5/2
      vecs[15] = '{32'h40A00000, 32'h40400000, 32'h3FD55555, 1'b0, 3'b000, 27}; // 5/3 round down
      vecs[16] = '{32'h3F800000, 32'h40E00000, 32'h3E124925, 1'b0, 3'b000, 27}; // 1/7

      bus.in_valid  = 1'b0;
      bus.x1        = '0;
      bus.x2        = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_y", bus.y, 32'd0);
      check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
      check("rst_flags", {29'd0, flags}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].a, vecs[i].b, y_r, ovf_r, fl_r, lat_r, seen_r);
         check($sformatf("v%0d_seen", i), {31'd0, seen_r}, 32'd1);
         check($sformatf("v%0d_y", i), y_r, vecs[i].y);
         check($sformatf("v%0d_ovf", i), {31'd0, ovf_r}, {31'd0, vecs[i].ovf});
         check($sformatf("v%0d_lat", i), lat_r, vecs[i].lat);
`ifdef FDIV_FLAGS_EN
         check($sformatf("v%0d_flags", i), {29'd0, fl_r}, {29'd0, vecs[i].fl});
`endif
         check($sformatf("v%0d_busy_in_done", i), {31'd0, bus.in_ready}, 32'd0);
         @(negedge clk);
         check($sformatf("v%0d_idle_after", i), {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      end

      // Back-pressure in DONE, plus a request pulse during CALC that must be dropped.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x1        = 32'h40C00000;
      bus.x2        = 32'h40000000;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("calc_in_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.in_valid = 1'b1;
      bus.x1       = 32'h00000000;
      bus.x2       = 32'h00000000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      seen_r = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) begin
            seen_r = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("stall_seen", {31'd0, seen_r}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d_y", i), bus.y, 32'h40400000);
         check($sformatf("stall%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("stall%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      check("release_in_ready_same_cycle", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      check("release_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      run_op(32'h3F800000, 32'h3F800000, y_r, ovf_r, fl_r, lat_r, seen_r);
      check("after_stall_y", y_r, 32'h3F800000);
      check("after_stall_lat", lat_r, 32'd27);
      @(negedge clk);

      // Reset asserted in the middle of CALC aborts the operation.
      bus.in_valid = 1'b1;
      bus.x1       = 32'h40C00000;
      bus.x2       = 32'h40000000;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("abort_y", bus.y, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_reset_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
      run_op(32'h40C00000, 32'h40000000, y_r, ovf_r, fl_r, lat_r, seen_r);
      check("post_reset_y", y_r, 32'h40400000);
      check("post_reset_lat", lat_r, 32'd27);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
